// File: rtl/axi_dma_w_mc.sv
// axi_dma_w_mc: CH-channel write DMA that streams words from local RAM to AXI4 write bursts.
// Optional feature macro AXI_DMA_W_BRESP_ERR_EN: a non-OKAY bresp stops the channel with SR.err set.
module axi_dma_w_mc #(
    parameter int AXI_AW = 32,
    parameter int AXI_DW = 128,
    parameter int AXI_IW = 4,
    parameter int AXI_LW = 8,
    parameter int RAM_AW = 20,
    parameter int APB_AW = 12,
    parameter int BL     = 16,
    parameter int CH     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                apb_we,
    input  logic [APB_AW-1:0]   apb_a,
    input  logic [31:0]         apb_d,
    output logic [31:0]         apb_q,
    output logic                ram_re,
    output logic [RAM_AW-1:0]   ram_a,
    input  logic [AXI_DW-1:0]   ram_q,
    output logic [AXI_IW-1:0]   axi_awid,
    output logic [AXI_AW-1:0]   axi_awaddr,
    output logic [AXI_LW-1:0]   axi_awlen,
    output logic [2:0]          axi_awsize,
    output logic [1:0]          axi_awburst,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [AXI_DW-1:0]   axi_wdata,
    output logic [AXI_DW/8-1:0] axi_wstrb,
    output logic                axi_wlast,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [AXI_IW-1:0]   axi_bid,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready,
    output logic [CH-1:0]       irq,
    output logic [2:0]          dbg_state
);
    // Handshakes: a beat moves on a clk edge where valid and ready are both high; a source
    // holds valid and its payload unchanged until that edge.
    localparam int L  = $clog2(AXI_DW / 8);
    localparam int LB = $clog2(BL);
    localparam int B  = L + LB;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int BW = LB + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_W, S_B} state_t;
    state_t state, state_n;

    logic [AXI_AW-1:0] dst [CH];
    logic [RAM_AW-1:0] src [CH];
    logic [31:0]       len [CH];
    logic [CH-1:0]     busy, done, err;

`ifndef AXI_DMA_W_BRESP_ERR_EN
    assign err = '0;
`endif

    // APB decode: channel n occupies byte offsets n*0x20 .. n*0x20+0x1F
    logic          a_hit;
    logic [CW-1:0] a_ch;
    logic [4:0]    a_off;
    logic [63:0]   dst_cur64;
    logic          wr_start;
    assign a_hit     = apb_a[APB_AW-1:5] < (APB_AW-5)'(CH);
    assign a_ch      = apb_a[5 +: CW];
    assign a_off     = apb_a[4:0];
    assign dst_cur64 = 64'(dst[a_ch]);
    assign wr_start  = apb_we && a_hit && (a_off == 5'h00) && apb_d[0];

    always_comb begin
        apb_q = '0;
        if (a_hit) begin
            case (a_off)
                5'h04:   apb_q = {29'b0, err[a_ch], busy[a_ch], done[a_ch]};
                5'h08:   apb_q = 32'(src[a_ch]);
                5'h0C:   apb_q = dst_cur64[31:0];
                5'h10:   apb_q = dst_cur64[63:32];
                5'h14:   apb_q = len[a_ch];
                default: apb_q = '0;
            endcase
        end
    end

    // Round-robin search begins at the channel after the one served last
    logic [CW-1:0] rr_ptr, grant_ch;
    logic          grant_vld;
    int            idx;
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int i = 0; i < CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= CH) idx = idx - CH;
            if (!grant_vld && busy[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CW'(idx);
            end
        end
    end

    logic [LB-1:0] g_off;
    logic [31:0]   room;
    logic [BW-1:0] beats_c;
    assign g_off   = dst[grant_ch][B-1:L];
    assign room    = 32'(BL) - 32'(g_off);
    assign beats_c = (len[grant_ch] < room) ? BW'(len[grant_ch]) : BW'(room);

    logic [CW-1:0]     g_ch;
    logic [AXI_AW-1:0] g_addr;
    logic [RAM_AW-1:0] g_src;
    logic [BW-1:0]     g_beats, rd_cnt, wr_cnt;
    logic              rd_pend, wp, rp, push, pop, b_acc;
    logic [1:0]        cnt, occ;
    logic [AXI_DW-1:0] skid_mem [2];

    assign axi_awvalid = (state == S_AW);
    assign axi_awid    = AXI_IW'(g_ch);
    assign axi_awaddr  = g_addr;
    assign axi_awlen   = AXI_LW'(g_beats - 1'b1);
    assign axi_awsize  = 3'(L);
    assign axi_awburst = 2'b01;

    assign axi_wvalid  = (cnt != 2'd0);
    assign axi_wdata   = skid_mem[rp];
    assign axi_wstrb   = '1;
    assign axi_wlast   = (wr_cnt == g_beats - 1'b1);
    assign push        = rd_pend;
    assign pop         = axi_wvalid && axi_wready;

    // In-flight reads count as occupancy so the two-entry buffer can never overflow
    assign occ    = cnt + {1'b0, rd_pend};
    assign ram_re = (state == S_W) && (rd_cnt != g_beats) && ((occ < 2'd2) || (occ == 2'd2 && pop));
    assign ram_a  = g_src + RAM_AW'(rd_cnt);

    assign axi_bready = (state == S_B) && (axi_bid == AXI_IW'(g_ch));
    assign b_acc      = axi_bready && axi_bvalid;

    assign irq       = done | err;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (|busy || wr_start) state_n = S_ARB;
            S_ARB:   state_n = grant_vld ? S_AW : S_IDLE;
            S_AW:    if (axi_awready) state_n = S_W;
            S_W:     if (pop && axi_wlast) state_n = S_B;
            S_B:     if (b_acc) state_n = S_ARB;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_ch        <= '0;
            g_addr      <= '0;
            g_src       <= '0;
            g_beats     <= '0;
            rr_ptr      <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            rd_pend     <= 1'b0;
            wp          <= 1'b0;
            rp          <= 1'b0;
            cnt         <= '0;
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
        end else begin
            if (state == S_ARB && grant_vld) begin
                g_ch    <= grant_ch;
                g_addr  <= dst[grant_ch];
                g_src   <= src[grant_ch];
                g_beats <= beats_c;
                rr_ptr  <= (int'(grant_ch) + 1 == CH) ? '0 : grant_ch + 1'b1;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
            end
            rd_pend <= ram_re;
            if (ram_re) rd_cnt <= rd_cnt + 1'b1;
            if (push) begin
                skid_mem[wp] <= ram_q;
                wp           <= ~wp;
            end
            if (pop) begin
                rp     <= ~rp;
                wr_cnt <= wr_cnt + 1'b1;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Burst completion is applied after APB writes so a done/err set wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                dst[c] <= '0;
                src[c] <= '0;
                len[c] <= '0;
            end
            busy <= '0;
            done <= '0;
`ifdef AXI_DMA_W_BRESP_ERR_EN
            err  <= '0;
`endif
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (apb_we && a_hit && a_ch == CW'(c)) begin
                    case (a_off)
                        5'h00: if (apb_d[0] && !busy[c]) begin
                            if (len[c] == 32'd0) done[c] <= 1'b1;
                            else                 busy[c] <= 1'b1;
                        end
                        5'h04: begin
                            if (apb_d[0]) done[c] <= 1'b0;
`ifdef AXI_DMA_W_BRESP_ERR_EN
                            if (apb_d[2]) err[c] <= 1'b0;
`endif
                        end
                        5'h08: if (!busy[c]) src[c] <= apb_d[RAM_AW-1:0];
                        5'h0C: if (!busy[c]) dst[c] <= AXI_AW'({dst_cur64[63:32], apb_d});
                        5'h10: if (!busy[c] && AXI_AW > 32) dst[c] <= AXI_AW'({apb_d, dst_cur64[31:0]});
                        5'h14: if (!busy[c]) len[c] <= apb_d;
                        default: ;
                    endcase
                end
                if (b_acc && g_ch == CW'(c)) begin
                    dst[c] <= dst[c] + (AXI_AW'(g_beats) << L);
                    src[c] <= src[c] + RAM_AW'(g_beats);
                    len[c] <= len[c] - 32'(g_beats);
                    if (len[c] == 32'(g_beats)) begin
                        done[c] <= 1'b1;
                        busy[c] <= 1'b0;
                    end
`ifdef AXI_DMA_W_BRESP_ERR_EN
                    if (axi_bresp != 2'b00) begin
                        err[c]  <= 1'b1;
                        busy[c] <= 1'b0;
                    end
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_dma_w_mc.sv
// tb_axi_dma_w_mc: directed bench for axi_dma_w_mc with a RAM model, AXI write slave and burst scoreboard.
module tb_axi_dma_w_mc;
    logic         clk, reset;
    logic         apb_we;
    logic [11:0]  apb_a;
    logic [31:0]  apb_d, apb_q;
    logic         ram_re;
    logic [19:0]  ram_a;
    logic [127:0] ram_q;
    logic [3:0]   axi_awid;
    logic [31:0]  axi_awaddr;
    logic [7:0]   axi_awlen;
    logic [2:0]   axi_awsize;
    logic [1:0]   axi_awburst;
    logic         axi_awvalid, axi_awready;
    logic [127:0] axi_wdata;
    logic [15:0]  axi_wstrb;
    logic         axi_wlast, axi_wvalid, axi_wready;
    logic [3:0]   axi_bid;
    logic [1:0]   axi_bresp;
    logic         axi_bvalid, axi_bready;
    logic [3:0]   irq;
    logic [2:0]   dbg_state;

    axi_dma_w_mc dut (
        .clk(clk), .reset(reset),
        .apb_we(apb_we), .apb_a(apb_a), .apb_d(apb_d), .apb_q(apb_q),
        .ram_re(ram_re), .ram_a(ram_a), .ram_q(ram_q),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .irq(irq), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ram_word(input logic [19:0] a);
        logic [31:0] x;
        x = {12'h0, a};
        return {x ^ 32'h5A5A5A5A, x + 32'd1, ~x, x};
    endfunction

    // scoreboard: {awid, awaddr, awlen} per burst and the data of every beat
    logic [43:0]  exp_aw_q[$];
    logic [127:0] exp_q[$];

    task automatic exp_burst(input int id, input logic [31:0] addr, input int alen, input int s);
        exp_aw_q.push_back({4'(id), addr, 8'(alen)});
        for (int i = 0; i <= alen; i++) exp_q.push_back(ram_word(20'(s + i)));
    endtask

    // controls written only by the main sequence
    bit stall = 0;
    bit bad_bid_req = 0;
    int err_at = -1;
    // state written only by the bus process
    int aw_cnt = 0;
    int b_num = 0;

    // RAM model and AXI slave: drive after posedge, observe on negedge
    initial begin : bus
        logic [3:0]   b_q[$];
        logic [43:0]  e;
        logic [127:0] prev_wdata;
        logic [31:0]  prev_awaddr;
        logic [3:0]   cur_id;
        logic [7:0]   cur_len;
        logic [19:0]  a_d;
        bit re_d, b_ack, bad_done, bad_active, prev_w_stall, prev_aw_stall;
        int wbeat;
        re_d = 0; a_d = '0; b_ack = 0; bad_done = 0; bad_active = 0;
        prev_w_stall = 0; prev_aw_stall = 0; prev_wdata = '0; prev_awaddr = '0;
        cur_id = '0; cur_len = '0; wbeat = 0;
        ram_q = '0; axi_awready = 1'b0; axi_wready = 1'b0;
        axi_bvalid = 1'b0; axi_bid = '0; axi_bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (re_d) ram_q = ram_word(a_d);
            axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_ack) begin
                axi_bvalid = 1'b0;
                b_ack = 0;
            end else if (!axi_bvalid && b_q.size() > 0) begin
                axi_bvalid = 1'b1;
                axi_bresp  = (b_num == err_at) ? 2'b10 : 2'b00;
                if (bad_bid_req && !bad_done) begin
                    axi_bid = b_q[0] + 4'd1;
                    bad_done = 1;
                    bad_active = 1;
                end else begin
                    axi_bid = b_q[0];
                end
            end else if (axi_bvalid && bad_active) begin
                axi_bid = b_q[0];
                bad_active = 0;
            end
            @(negedge clk);
            re_d = ram_re;
            a_d  = ram_a;
            if (prev_aw_stall) begin
                check("awvalid_hold", axi_awvalid, 1);
                check("awaddr_hold", axi_awaddr, prev_awaddr);
            end
            prev_aw_stall = axi_awvalid && !axi_awready;
            prev_awaddr   = axi_awaddr;
            if (prev_w_stall) begin
                check("wvalid_hold", axi_wvalid, 1);
                check("wdata_hold", axi_wdata, prev_wdata);
            end
            prev_w_stall = axi_wvalid && !axi_wready;
            prev_wdata   = axi_wdata;
            if (axi_awvalid && axi_awready) begin
                aw_cnt++;
                if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    e = exp_aw_q.pop_front();
                    check("awid", axi_awid, e[43:40]);
                    check("awaddr", axi_awaddr, e[39:8]);
                    check("awlen", axi_awlen, e[7:0]);
                    check("awsize", axi_awsize, 3'd4);
                    check("awburst", axi_awburst, 2'b01);
                end
                cur_id  = axi_awid;
                cur_len = axi_awlen;
                wbeat   = 0;
            end
            if (axi_wvalid && axi_wready) begin
                if (exp_q.size() == 0) check("w_unexpected", 1, 0);
                else check("wdata", axi_wdata, exp_q.pop_front());
                check("wstrb", axi_wstrb, 16'hFFFF);
                check("wlast", axi_wlast, wbeat == int'(cur_len));
                if (axi_wlast) b_q.push_back(cur_id);
                wbeat++;
            end
            if (axi_bvalid) begin
                if (bad_active) check("bready_bad_bid", axi_bready, 0);
                else if (axi_bready) begin
                    b_ack = 1;
                    void'(b_q.pop_front());
                    b_num++;
                end
            end
        end
    end

    // driver tasks
    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        apb_we = 1'b1; apb_a = a; apb_d = d;
        @(posedge clk); #1;
        apb_we = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        apb_a = a;
        #1;
        check(tag, apb_q, exp);
        @(posedge clk); #1;
    endtask

    task automatic setup(input int ch, input logic [31:0] d, input logic [31:0] s, input logic [31:0] n);
        apb_wr(12'(ch * 32 + 12), d);
        apb_wr(12'(ch * 32 + 8), s);
        apb_wr(12'(ch * 32 + 20), n);
    endtask

    task automatic wait_irq(input string tag, input logic [3:0] mask);
        for (int i = 0; i < 4000; i++) begin
            if ((irq & mask) == mask) break;
            @(posedge clk); #1;
        end
        check(tag, irq & mask, mask);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_aw_left"}, 32'(exp_aw_q.size()), 0);
        check({tag, "_w_left"}, 32'(exp_q.size()), 0);
    endtask

    initial begin : main
        int aw_before;
        reset = 1'b1; apb_we = 1'b0; apb_a = '0; apb_d = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_irq", irq, 0);
        check("rst_state", dbg_state, 0);
        apb_a = 12'h004; #1;
        check("rst_sr", apb_q, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 40 beats from an aligned address: 16 + 16 + 8; first B carries a wrong bid
        setup(0, 32'h1000, 0, 40);
        exp_burst(0, 32'h1000, 15, 0);
        exp_burst(0, 32'h1100, 15, 16);
        exp_burst(0, 32'h1200, 7, 32);
        bad_bid_req = 1;
        apb_wr(12'h000, 1);
        reg_chk("t1_sr_busy", 12'h004, 32'h2);
        wait_irq("t1_irq", 4'b0001);
        check("t1_irq_only0", irq, 4'b0001);
        reg_chk("t1_sr", 12'h004, 32'h1);
        reg_chk("t1_dst", 12'h00C, 32'h1280);
        reg_chk("t1_src", 12'h008, 32'd40);
        reg_chk("t1_len", 12'h014, 32'd0);
        apb_wr(12'h004, 1);
        check("t1_irq_clr", irq, 0);

        // start on the last beat slot of a burst window
        setup(0, 32'h10F0, 100, 3);
        exp_burst(0, 32'h10F0, 0, 100);
        exp_burst(0, 32'h1100, 1, 101);
        apb_wr(12'h000, 1);
        wait_irq("t2_irq", 4'b0001);
        reg_chk("t2_dst", 12'h00C, 32'h1120);
        reg_chk("t2_src", 12'h008, 32'd103);
        reg_chk("t2_len", 12'h014, 32'd0);
        apb_wr(12'h004, 1);

        // four channels: round-robin interleaves one burst each
        for (int n = 0; n < 4; n++) setup(n, 32'h2000 + 32'(n) * 32'h1000, 32'(n * 64), 32);
        for (int n = 0; n < 4; n++) exp_burst(n, 32'h2000 + 32'(n) * 32'h1000, 15, n * 64);
        for (int n = 0; n < 4; n++) exp_burst(n, 32'h2100 + 32'(n) * 32'h1000, 15, n * 64 + 16);
        for (int n = 0; n < 4; n++) apb_wr(12'(n * 32), 1);
        wait_irq("t3_irq", 4'b1111);
        for (int n = 0; n < 4; n++) reg_chk("t3_sr", 12'(n * 32 + 4), 32'h1);
        for (int n = 0; n < 4; n++) apb_wr(12'(n * 32 + 4), 1);
        check("t3_irq_clr", irq, 0);

        // random awready/wready stalls
        stall = 1;
        setup(1, 32'h8040, 300, 20);
        exp_burst(1, 32'h8040, 11, 300);
        exp_burst(1, 32'h8100, 7, 312);
        apb_wr(12'h020, 1);
        wait_irq("t4_irq", 4'b0010);
        stall = 0;
        reg_chk("t4_dst", 12'h02C, 32'h8180);
        reg_chk("t4_len", 12'h034, 32'd0);
        apb_wr(12'h024, 1);

        // writes while busy are ignored
        setup(2, 32'h9000, 500, 48);
        exp_burst(2, 32'h9000, 15, 500);
        exp_burst(2, 32'h9100, 15, 516);
        exp_burst(2, 32'h9200, 15, 532);
        apb_wr(12'h040, 1);
        apb_wr(12'h044, 32'h7);
        apb_wr(12'h054, 5);
        apb_wr(12'h048, 7);
        apb_wr(12'h04C, 0);
        apb_wr(12'h040, 1);
        reg_chk("t5_sr_busy", 12'h044, 32'h2);
        wait_irq("t5_irq", 4'b0100);
        reg_chk("t5_len", 12'h054, 32'd0);
        reg_chk("t5_src", 12'h048, 32'd548);
        reg_chk("t5_dst", 12'h04C, 32'h9300);
        reg_chk("t5_sr", 12'h044, 32'h1);
        apb_wr(12'h044, 1);

        // zero-length start: done on the next edge, no AW
        apb_wr(12'h074, 0);
        aw_before = aw_cnt;
        apb_wr(12'h060, 1);
        check("t5_zero_irq", irq, 4'b1000);
        reg_chk("t5_zero_sr", 12'h064, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        check("t5_zero_no_aw", 32'(aw_cnt - aw_before), 0);
        apb_wr(12'h064, 1);

        // SLVERR on the second of three bursts
        setup(0, 32'hA000, 600, 40);
        err_at = b_num + 1;
        exp_burst(0, 32'hA000, 15, 600);
        exp_burst(0, 32'hA100, 15, 616);
`ifndef AXI_DMA_W_BRESP_ERR_EN
        exp_burst(0, 32'hA200, 7, 632);
`endif
        apb_wr(12'h000, 1);
        wait_irq("t6_irq", 4'b0001);
`ifdef AXI_DMA_W_BRESP_ERR_EN
        reg_chk("t6_sr", 12'h004, 32'h4);
        reg_chk("t6_len", 12'h014, 32'd8);
        reg_chk("t6_dst", 12'h00C, 32'hA200);
`else
        reg_chk("t6_sr", 12'h004, 32'h1);
        reg_chk("t6_len", 12'h014, 32'd0);
        reg_chk("t6_dst", 12'h00C, 32'hA280);
`endif
        err_at = -1;
        apb_wr(12'h004, 32'h5);
        check("t6_irq_clr", irq, 0);

        // final report
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
